// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: converts single 32-bit access requests into T1/T2 bus cycles on a bus
// that may be 32 or 16 bits wide. A word access answered with a 16-bit size request is
// split into a low-half and a high-half cycle. An optional wait-state limit ends a stalled
// access with an error.
//
// Ports:
//   CLK, RESET, CE        clock, synchronous active-high reset, clock enable
//   REQ, REQ_A, REQ_WR    request strobe, byte address, 1=write
//   REQ_BEn, REQ_WD       active-low byte enables, write data
//   BUSY, DONE, ERR, RD   access in progress, one-cycle completion, timeout flag, read data
//   BUS_A, BUS_RW         bus address [31:1], 1=read
//   BUS_DAn, BUS_BEn      data strobe (active low), byte enables
//   BUS_DO, BUS_DI        write / read data
//   BUS_READYn, BUS_SZRQn ready, 16-bit size request (both active low)
module bus_cycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        REQ,
  input  logic [31:0] REQ_A,
  input  logic        REQ_WR,
  input  logic [3:0]  REQ_BEn,
  input  logic [31:0] REQ_WD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RD,
  output logic [31:1] BUS_A,
  output logic        BUS_RW,
  output logic        BUS_DAn,
  output logic [3:0]  BUS_BEn,
  output logic [31:0] BUS_DO,
  input  logic [31:0] BUS_DI,
  input  logic        BUS_READYn,
  input  logic        BUS_SZRQn
);

  typedef enum logic [1:0] {StIdle, StT1, StT2} state_e;

  state_e      state_q, state_d;
  logic        hi_q, hi_d;
  logic [15:0] wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [31:1] bus_a_q, bus_a_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_dan_q, bus_dan_d;
  logic [3:0]  bus_ben_q, bus_ben_d;
  logic [31:0] bus_do_q, bus_do_d;
  logic [3:0]  lat_ben_q, lat_ben_d;
  logic [15:0] lo_q, lo_d;

  logic lo_en, hi_en, is_word, one_half, timeout;

  // Byte-enable halves come from the request, not the bus copy, which changes on a split.
  assign hi_en    = (lat_ben_q[3:2] != 2'b11);
  assign lo_en    = (lat_ben_q[1:0] != 2'b11);
  assign is_word  = hi_en && lo_en && !bus_a_q[1];
  assign one_half = hi_en ^ lo_en;
  assign timeout  = (WAIT_LIMIT != 0) && (wait_q == 16'(WAIT_LIMIT));

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rd_d      = rd_q;
    bus_a_d   = bus_a_q;
    bus_rw_d  = bus_rw_q;
    bus_dan_d = bus_dan_q;
    bus_ben_d = bus_ben_q;
    bus_do_d  = bus_do_q;
    lat_ben_d = lat_ben_q;
    lo_d      = lo_q;

    if (CE) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ) begin
            state_d   = StT1;
            busy_d    = 1'b1;
            hi_d      = 1'b0;
            wait_d    = '0;
            bus_a_d   = REQ_A[31:1];
            bus_rw_d  = ~REQ_WR;
            bus_ben_d = REQ_BEn;
            bus_do_d  = REQ_WD;
            lat_ben_d = REQ_BEn;
          end
        end
        StT1: begin
          state_d   = StT2;
          bus_dan_d = 1'b0;
        end
        StT2: begin
          if (!BUS_READYn) begin
            if (!hi_q && !BUS_SZRQn && is_word) begin
              // 16-bit bus answered a word: keep the low half, rerun for the upper half.
              state_d    = StT1;
              lo_d       = BUS_DI[15:0];
              hi_d       = 1'b1;
              bus_dan_d  = 1'b1;
              bus_a_d[1] = 1'b1;
              bus_ben_d  = {lat_ben_q[3:2], 2'b11};
              bus_do_d   = {bus_do_q[31:16], bus_do_q[31:16]};
              wait_d     = '0;
            end else begin
              if (bus_rw_q) begin
                if (hi_q)                       rd_d = {BUS_DI[15:0], lo_q};
                else if (!BUS_SZRQn && one_half) rd_d = {16'h0, BUS_DI[15:0]};
                else                            rd_d = BUS_DI;
              end
              state_d   = StIdle;
              done_d    = 1'b1;
              busy_d    = 1'b0;
              bus_dan_d = 1'b1;
              bus_ben_d = 4'hF;
              hi_d      = 1'b0;
              wait_d    = '0;
            end
          end else if (timeout) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            err_d     = 1'b1;
            rd_d      = '0;
            busy_d    = 1'b0;
            bus_dan_d = 1'b1;
            bus_ben_d = 4'hF;
            hi_d      = 1'b0;
            wait_d    = '0;
          end else if (wait_q != 16'hFFFF) begin
            wait_d = wait_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      hi_q      <= 1'b0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      bus_a_q   <= '0;
      bus_rw_q  <= 1'b1;
      bus_dan_q <= 1'b1;
      bus_ben_q <= 4'hF;
      bus_do_q  <= '0;
      lat_ben_q <= 4'hF;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      bus_a_q   <= bus_a_d;
      bus_rw_q  <= bus_rw_d;
      bus_dan_q <= bus_dan_d;
      bus_ben_q <= bus_ben_d;
      bus_do_q  <= bus_do_d;
      lat_ben_q <= lat_ben_d;
      lo_q      <= lo_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign RD      = rd_q;
  assign BUS_A   = bus_a_q;
  assign BUS_RW  = bus_rw_q;
  assign BUS_DAn = bus_dan_q;
  assign BUS_BEn = bus_ben_q;
  assign BUS_DO  = bus_do_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl (WAIT_LIMIT=4): reset values, 32-bit read, busy-ignore,
// back-to-back 16-bit split read, split write, halfword read, timeout, reset abort, CE freeze.
module tb_bus_cycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, CE, REQ, REQ_WR;
  logic [31:0] REQ_A, REQ_WD, BUS_DI;
  logic [3:0]  REQ_BEn;
  logic        BUS_READYn, BUS_SZRQn;
  logic        BUSY, DONE, ERR, BUS_RW, BUS_DAn;
  logic [31:0] RD, BUS_DO;
  logic [31:1] BUS_A;
  logic [3:0]  BUS_BEn;

  int n_cmp = 0;
  int n_err = 0;

  bus_cycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CE        (CE),
    .REQ       (REQ),
    .REQ_A     (REQ_A),
    .REQ_WR    (REQ_WR),
    .REQ_BEn   (REQ_BEn),
    .REQ_WD    (REQ_WD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .RD        (RD),
    .BUS_A     (BUS_A),
    .BUS_RW    (BUS_RW),
    .BUS_DAn   (BUS_DAn),
    .BUS_BEn   (BUS_BEn),
    .BUS_DO    (BUS_DO),
    .BUS_DI    (BUS_DI),
    .BUS_READYn(BUS_READYn),
    .BUS_SZRQn (BUS_SZRQn)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] a, input logic wr, input logic [3:0] ben,
                         input logic [31:0] wd);
    REQ = 1'b1; REQ_A = a; REQ_WR = wr; REQ_BEn = ben; REQ_WD = wd;
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b0; REQ = 1'b0; REQ_A = '0; REQ_WR = 1'b0; REQ_BEn = 4'hF;
    REQ_WD = '0; BUS_DI = '0; BUS_READYn = 1'b1; BUS_SZRQn = 1'b1;

    // Reset wins even with CE low.
    step();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_rd", RD, 32'd0);
    chk("rst_a", 32'(BUS_A), 32'd0);
    chk("rst_rw", 32'(BUS_RW), 32'd1);
    chk("rst_dan", 32'(BUS_DAn), 32'd1);
    chk("rst_ben", 32'(BUS_BEn), 32'hF);
    chk("rst_do", BUS_DO, 32'd0);
    RESET = 1'b0; CE = 1'b1;
    step();
    chk("idle_busy", 32'(BUSY), 32'd0);

    // 32-bit read, no waits; a second REQ held during the access must be ignored.
    request(32'h100, 1'b0, 4'h0, 32'h0);
    BUS_DI = 32'hCAFEF00D; BUS_READYn = 1'b0; BUS_SZRQn = 1'b1;
    step();                                   // T1
    chk("r32_t1_busy", 32'(BUSY), 32'd1);
    chk("r32_t1_dan", 32'(BUS_DAn), 32'd1);
    chk("r32_t1_a", 32'(BUS_A), 32'h80);
    chk("r32_t1_rw", 32'(BUS_RW), 32'd1);
    chk("r32_t1_ben", 32'(BUS_BEn), 32'h0);
    REQ_A = 32'h300;
    step();                                   // T2
    chk("r32_t2_dan", 32'(BUS_DAn), 32'd0);
    chk("r32_ignore_a", 32'(BUS_A), 32'h80);
    step();                                   // DONE
    chk("r32_done", 32'(DONE), 32'd1);
    chk("r32_err", 32'(ERR), 32'd0);
    chk("r32_rd", RD, 32'hCAFEF00D);
    chk("r32_busy", 32'(BUSY), 32'd0);
    chk("r32_dan", 32'(BUS_DAn), 32'd1);
    chk("r32_ben", 32'(BUS_BEn), 32'hF);

    // Back-to-back: word read on a 16-bit bus, one wait state in the first half.
    request(32'h200, 1'b0, 4'h0, 32'h0);
    BUS_DI = 32'h0000BEEF; BUS_READYn = 1'b1; BUS_SZRQn = 1'b0;
    step();                                   // T1
    chk("b2b_done_clr", 32'(DONE), 32'd0);
    chk("w16_t1_a", 32'(BUS_A), 32'h100);
    chk("w16_t1_busy", 32'(BUSY), 32'd1);
    REQ = 1'b0;
    step();                                   // T2
    step();                                   // wait state
    chk("w16_wait_dan", 32'(BUS_DAn), 32'd0);
    chk("w16_wait_done", 32'(DONE), 32'd0);
    BUS_READYn = 1'b0;
    step();                                   // split -> T1 upper half
    chk("w16_split_dan", 32'(BUS_DAn), 32'd1);
    chk("w16_split_a", 32'(BUS_A), 32'h101);
    chk("w16_split_ben", 32'(BUS_BEn), 32'b0011);
    chk("w16_split_done", 32'(DONE), 32'd0);
    BUS_DI = 32'h0000DEAD;
    step();                                   // T2 upper
    chk("w16_t2b_dan", 32'(BUS_DAn), 32'd0);
    step();                                   // DONE
    chk("w16_done", 32'(DONE), 32'd1);
    chk("w16_rd", RD, 32'hDEADBEEF);
    chk("w16_err", 32'(ERR), 32'd0);

    // Word write on a 16-bit bus.
    request(32'h400, 1'b1, 4'h0, 32'h12345678);
    BUS_DI = 32'hFFFFFFFF;
    step();                                   // T1
    chk("wr_t1_rw", 32'(BUS_RW), 32'd0);
    chk("wr_t1_do", BUS_DO, 32'h12345678);
    REQ = 1'b0;
    step();                                   // T2
    step();                                   // split
    chk("wr_split_do", BUS_DO, 32'h12341234);
    chk("wr_split_ben", 32'(BUS_BEn), 32'b0011);
    chk("wr_split_dan", 32'(BUS_DAn), 32'd1);
    step();                                   // T2 upper
    step();                                   // DONE
    chk("wr_done", 32'(DONE), 32'd1);
    chk("wr_rd_hold", RD, 32'hDEADBEEF);
    step();
    chk("wr_done_pulse", 32'(DONE), 32'd0);

    // Halfword read with size request: no split.
    request(32'h500, 1'b0, 4'b1100, 32'h0);
    BUS_DI = 32'hFFFFA5A5; BUS_READYn = 1'b0; BUS_SZRQn = 1'b0;
    step();                                   // T1
    chk("hw_t1_ben", 32'(BUS_BEn), 32'b1100);
    REQ = 1'b0;
    step();                                   // T2
    step();                                   // DONE
    chk("hw_done", 32'(DONE), 32'd1);
    chk("hw_rd", RD, 32'h0000A5A5);

    // Timeout after 4 wait cycles.
    request(32'h600, 1'b0, 4'h0, 32'h0);
    BUS_READYn = 1'b1; BUS_SZRQn = 1'b1;
    step();                                   // T1
    REQ = 1'b0;
    step();                                   // T2
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_done", 32'(DONE), 32'd0);
      chk("to_wait_dan", 32'(BUS_DAn), 32'd0);
    end
    step();
    chk("to_done", 32'(DONE), 32'd1);
    chk("to_err", 32'(ERR), 32'd1);
    chk("to_rd", RD, 32'd0);
    chk("to_dan", 32'(BUS_DAn), 32'd1);
    step();
    chk("to_err_clr", 32'(ERR), 32'd0);

    // Reset in T2 aborts with no DONE.
    request(32'h700, 1'b0, 4'h0, 32'h0);
    step();                                   // T1
    REQ = 1'b0;
    step();                                   // T2
    RESET = 1'b1;
    step();
    chk("ab_dan", 32'(BUS_DAn), 32'd1);
    chk("ab_busy", 32'(BUSY), 32'd0);
    chk("ab_done", 32'(DONE), 32'd0);
    RESET = 1'b0; BUS_READYn = 1'b0;
    step();
    step();
    chk("ab_no_done", 32'(DONE), 32'd0);

    // CE low mid-access and during the DONE cycle freezes everything.
    request(32'h800, 1'b0, 4'h0, 32'h0);
    BUS_DI = 32'h11223344; BUS_READYn = 1'b1; BUS_SZRQn = 1'b1;
    step();                                   // T1
    REQ = 1'b0;
    step();                                   // T2
    CE = 1'b0; BUS_READYn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ce_dan", 32'(BUS_DAn), 32'd0);
      chk("ce_busy", 32'(BUSY), 32'd1);
      chk("ce_done", 32'(DONE), 32'd0);
    end
    CE = 1'b1;
    step();                                   // DONE
    chk("ce_fin_done", 32'(DONE), 32'd1);
    chk("ce_fin_rd", RD, 32'h11223344);
    CE = 1'b0;
    step();
    step();
    chk("ce_done_hold", 32'(DONE), 32'd1);
    CE = 1'b1;
    step();
    chk("ce_done_clr", 32'(DONE), 32'd0);

    RESET = 1'b1;
    step();
    chk("rst2_rd", RD, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
